// File: rtl/xpb_table_gen.sv
// Run-time xpb table generator: entry[k] = (k * base) mod modulus, served on parallel lookup lanes.
// Optional macro XPB_TABLE_LOOKUP_PIPE_EN adds a second lookup output register stage (latency 2).
module xpb_table_gen #(
    parameter int unsigned DATA_W    = 1024,
    parameter int unsigned IDX_W     = 5,
    parameter int unsigned NUM_LANES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [DATA_W-1:0]             base_in,
    input  logic [DATA_W-1:0]             mod_in,
    output logic                          busy,
    output logic                          ready,
    output logic                          cfg_err,
    input  logic [NUM_LANES-1:0]          lk_valid_in,
    input  logic [NUM_LANES*IDX_W-1:0]    lk_idx_in,
    output logic [NUM_LANES-1:0]          lk_valid_out,
    output logic [NUM_LANES*DATA_W-1:0]   lk_data_out,
    output logic [NUM_LANES-1:0]          lk_err
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {ST_IDLE, ST_GEN, ST_READY} state_t;

    state_t                      state_q, state_d;
    logic                        busy_q, busy_d;
    logic                        ready_q, ready_d;
    logic                        cfg_err_q, cfg_err_d;
    logic [DATA_W-1:0]           base_q, base_d;
    logic [DATA_W-1:0]           mod_q, mod_d;
    logic [DATA_W-1:0]           acc_q, acc_d;
    logic [IDX_W-1:0]            k_q, k_d;
    logic [NUM_LANES-1:0]        lk_valid_q, lk_valid_d;
    logic [NUM_LANES-1:0]        lk_err_q, lk_err_d;
    logic [NUM_LANES*DATA_W-1:0] lk_data_q, lk_data_d;

    logic [DATA_W-1:0]           tbl_q [DEPTH];
    logic                        tbl_we;
    logic [IDX_W-1:0]            tbl_waddr;
    logic [DATA_W-1:0]           tbl_wdata;

    logic                        cfg_bad;
    logic [DATA_W:0]             sum;
    logic [DATA_W-1:0]           red;

    // Next-state, table write and generation step
    always_comb begin
        state_d   = state_q;
        cfg_err_d = cfg_err_q;
        base_d    = base_q;
        mod_d     = mod_q;
        acc_d     = acc_q;
        k_d       = k_q;
        tbl_we    = 1'b0;
        tbl_waddr = k_q;

        cfg_bad = (mod_in == '0) || (base_in >= mod_in);
        sum     = {1'b0, acc_q} + {1'b0, base_q};
        red     = (sum >= {1'b0, mod_q}) ? DATA_W'(sum - {1'b0, mod_q}) : sum[DATA_W-1:0];
        tbl_wdata = red;

        if (start) begin
            if (cfg_bad) begin
                cfg_err_d = 1'b1;
                state_d   = ST_IDLE;
            end else begin
                base_d    = base_in;
                mod_d     = mod_in;
                acc_d     = '0;
                k_d       = IDX_W'(1);
                cfg_err_d = 1'b0;
                tbl_we    = 1'b1;
                tbl_waddr = '0;
                tbl_wdata = '0;
                state_d   = ST_GEN;
            end
        end else if (state_q == ST_GEN) begin
            tbl_we = 1'b1;
            acc_d  = red;
            k_d    = IDX_W'(k_q + 1'b1);
            if (k_q == IDX_W'(DEPTH - 1)) begin
                state_d = ST_READY;
            end
        end

        busy_d  = (state_d == ST_GEN);
        ready_d = (state_d == ST_READY);
    end

    // Lookup lanes: served against ready as registered at request time
    always_comb begin
        lk_valid_d = '0;
        lk_err_d   = '0;
        lk_data_d  = lk_data_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lk_valid_in[i]) begin
                if (ready_q) begin
                    lk_valid_d[i] = 1'b1;
                    lk_data_d[i*DATA_W +: DATA_W] = tbl_q[lk_idx_in[i*IDX_W +: IDX_W]];
                end else begin
                    lk_err_d[i] = 1'b1;
                    lk_data_d[i*DATA_W +: DATA_W] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            cfg_err_q  <= 1'b0;
            base_q     <= '0;
            mod_q      <= '0;
            acc_q      <= '0;
            k_q        <= '0;
            lk_valid_q <= '0;
            lk_err_q   <= '0;
            lk_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            cfg_err_q  <= cfg_err_d;
            base_q     <= base_d;
            mod_q      <= mod_d;
            acc_q      <= acc_d;
            k_q        <= k_d;
            lk_valid_q <= lk_valid_d;
            lk_err_q   <= lk_err_d;
            lk_data_q  <= lk_data_d;
        end
    end

    // Table storage needs no reset; ready gates every use
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl_q[tbl_waddr] <= tbl_wdata;
        end
    end

    assign busy    = busy_q;
    assign ready   = ready_q;
    assign cfg_err = cfg_err_q;

`ifdef XPB_TABLE_LOOKUP_PIPE_EN
    logic [NUM_LANES-1:0]        lk_valid_p_q;
    logic [NUM_LANES-1:0]        lk_err_p_q;
    logic [NUM_LANES*DATA_W-1:0] lk_data_p_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_valid_p_q <= '0;
            lk_err_p_q   <= '0;
            lk_data_p_q  <= '0;
        end else begin
            lk_valid_p_q <= lk_valid_q;
            lk_err_p_q   <= lk_err_q;
            lk_data_p_q  <= lk_data_q;
        end
    end

    assign lk_valid_out = lk_valid_p_q;
    assign lk_err       = lk_err_p_q;
    assign lk_data_out  = lk_data_p_q;
`else
    assign lk_valid_out = lk_valid_q;
    assign lk_err       = lk_err_q;
    assign lk_data_out  = lk_data_q;
`endif

endmodule

// File: tb/tb_xpb_table_gen.sv
// Directed self-checking bench for xpb_table_gen at DATA_W=16, IDX_W=3, two lanes.
module tb_xpb_table_gen;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned NL     = 2;
`ifdef XPB_TABLE_LOOKUP_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start;
    logic [DATA_W-1:0]      base_in;
    logic [DATA_W-1:0]      mod_in;
    logic                   busy;
    logic                   ready;
    logic                   cfg_err;
    logic [NL-1:0]          lk_valid_in;
    logic [NL*IDX_W-1:0]    lk_idx_in;
    logic [NL-1:0]          lk_valid_out;
    logic [NL*DATA_W-1:0]   lk_data_out;
    logic [NL-1:0]          lk_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] tab_nowrap [8] = '{16'h0000, 16'h1234, 16'h2468, 16'h369C,
                                    16'h48D0, 16'h5B04, 16'h6D38, 16'h7F6C};
    logic [15:0] tab_wrap   [8] = '{16'h0000, 16'h9000, 16'h200F, 16'hB00F,
                                    16'h401E, 16'hD01E, 16'h602D, 16'hF02D};

    xpb_table_gen #(.DATA_W(DATA_W), .IDX_W(IDX_W), .NUM_LANES(NL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_in(base_in), .mod_in(mod_in),
        .busy(busy), .ready(ready), .cfg_err(cfg_err),
        .lk_valid_in(lk_valid_in), .lk_idx_in(lk_idx_in),
        .lk_valid_out(lk_valid_out), .lk_data_out(lk_data_out), .lk_err(lk_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request cycle and wait until its response is visible
    task automatic lookup(input int i0, input bit v0, input int i1, input bit v1);
        lk_idx_in   = {IDX_W'(i1), IDX_W'(i0)};
        lk_valid_in = {v1, v0};
        step();
        lk_valid_in = '0;
        for (int j = 1; j < LAT; j++) step();
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] m);
        base_in = b;
        mod_in  = m;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    // Count busy cycles after a start until ready, bounded
    task automatic wait_ready(input string name, input int exp_busy);
        int n = 0;
        int both = 0;
        while (busy && n < 50) begin
            if (busy && ready) both++;
            n++;
            step();
        end
        n_checks++;
        if (n !== exp_busy) begin
            n_fail++;
            $display("FAIL %s busy_cycles actual=%0d required=%0d", name, n, exp_busy);
        end
        n_checks++;
        if (ready !== 1'b1 || both != 0) begin
            n_fail++;
            $display("FAIL %s ready_after_gen actual ready=%b overlap=%0d required ready=1 overlap=0",
                     name, ready, both);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; base_in = '0; mod_in = '0;
        lk_valid_in = '0; lk_idx_in = '0;
        #12;
        n_checks++;
        if ({busy, ready, cfg_err, lk_valid_out, lk_err} !== '0 || lk_data_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs actual b=%b r=%b e=%b v=%b le=%b d=%h required all zero",
                     busy, ready, cfg_err, lk_valid_out, lk_err, lk_data_out);
        end
        rst_n = 1'b1;
        step();
        lookup(3, 1'b1, 0, 1'b0);
        n_checks++;
        if (lk_err !== 2'b01 || lk_valid_out !== 2'b00 || lk_data_out[15:0] !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_lookup actual err=%b v=%b d=%h required err=01 v=00 d=0000",
                     lk_err, lk_valid_out, lk_data_out[15:0]);
        end
        step();
        n_checks++;
        if (lk_err !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_lookup_err_pulse actual=%b required=00", lk_err);
        end
    endtask

    task automatic check_table(input string name, input logic [15:0] t [8]);
        for (int k = 0; k < 8; k++) begin
            lookup(k, 1'b1, 7 - k, 1'b1);
            n_checks++;
            if (lk_valid_out !== 2'b11 || lk_err !== 2'b00 ||
                lk_data_out[15:0] !== t[k] || lk_data_out[31:16] !== t[7-k]) begin
                n_fail++;
                $display("FAIL %s idx%0d actual v=%b d0=%h d1=%h required v=11 d0=%h d1=%h",
                         name, k, lk_valid_out, lk_data_out[15:0], lk_data_out[31:16], t[k], t[7-k]);
            end
        end
    endtask

    task automatic test_nowrap();
        do_start(16'h1234, 16'hFFF1);
        wait_ready("nowrap", 7);
        check_table("nowrap", tab_nowrap);
        step();
        n_checks++;
        if (lk_valid_out !== 2'b00 || lk_data_out[15:0] !== 16'h7F6C || lk_data_out[31:16] !== 16'h0000) begin
            n_fail++;
            $display("FAIL idle_hold actual v=%b d0=%h d1=%h required v=00 d0=7f6c d1=0000",
                     lk_valid_out, lk_data_out[15:0], lk_data_out[31:16]);
        end
    endtask

    task automatic test_wrap();
        do_start(16'h9000, 16'hFFF1);
        wait_ready("wrap", 7);
        check_table("wrap", tab_wrap);
        lookup(2, 1'b1, 7, 1'b1);
        n_checks++;
        if (lk_data_out[15:0] !== 16'h200F || lk_data_out[31:16] !== 16'hF02D || lk_valid_out !== 2'b11) begin
            n_fail++;
            $display("FAIL wrap_dual actual v=%b d0=%h d1=%h required v=11 d0=200f d1=f02d",
                     lk_valid_out, lk_data_out[15:0], lk_data_out[31:16]);
        end
        lookup(5, 1'b1, 5, 1'b1);
        n_checks++;
        if (lk_data_out[15:0] !== 16'hD01E || lk_data_out[31:16] !== 16'hD01E) begin
            n_fail++;
            $display("FAIL wrap_same_idx actual d0=%h d1=%h required d0=d01e d1=d01e",
                     lk_data_out[15:0], lk_data_out[31:16]);
        end
    endtask

    task automatic test_cfg_err();
        int nb = 0;
        do_start(16'hFFF1, 16'hFFF1);
        for (int j = 0; j < 5; j++) begin
            if (busy) nb++;
            step();
        end
        n_checks++;
        if (cfg_err !== 1'b1 || ready !== 1'b0 || nb != 0) begin
            n_fail++;
            $display("FAIL cfg_err_base_eq_mod actual err=%b ready=%b busy_cycles=%0d required 1 0 0",
                     cfg_err, ready, nb);
        end
        lookup(1, 1'b0, 1, 1'b1);
        n_checks++;
        if (lk_err !== 2'b10 || lk_valid_out !== 2'b00) begin
            n_fail++;
            $display("FAIL cfg_err_lookup actual err=%b v=%b required err=10 v=00", lk_err, lk_valid_out);
        end
        do_start(16'h1234, 16'hFFF1);
        n_checks++;
        if (cfg_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_err_clear actual err=%b busy=%b required err=0 busy=1", cfg_err, busy);
        end
        wait_ready("cfg_recover", 7);
        do_start(16'h0000, 16'h0000);
        n_checks++;
        if (cfg_err !== 1'b1 || ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_mod_zero actual err=%b ready=%b busy=%b required 1 0 0",
                     cfg_err, ready, busy);
        end
    endtask

    task automatic test_restart();
        do_start(16'h1234, 16'hFFF1);
        step();
        step();
        do_start(16'h9000, 16'hFFF1);
        wait_ready("restart", 7);
        check_table("restart", tab_wrap);
    endtask

    task automatic test_start_in_ready();
        base_in = 16'h1234;
        mod_in  = 16'hFFF1;
        start   = 1'b1;
        lk_idx_in   = {IDX_W'(3), IDX_W'(7)};
        lk_valid_in = 2'b11;
        step();
        start       = 1'b0;
        lk_valid_in = '0;
        n_checks++;
        if (ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_in_ready_flags actual ready=%b busy=%b required 0 1", ready, busy);
        end
        if (LAT == 2) step();
        n_checks++;
        if (lk_valid_out !== 2'b11 || lk_data_out[15:0] !== 16'hF02D || lk_data_out[31:16] !== 16'hB00F) begin
            n_fail++;
            $display("FAIL start_in_ready_old_table actual v=%b d0=%h d1=%h required v=11 d0=f02d d1=b00f",
                     lk_valid_out, lk_data_out[15:0], lk_data_out[31:16]);
        end
        wait_ready("start_in_ready", (LAT == 2) ? 6 : 7);
        lookup(3, 1'b1, 7, 1'b1);
        n_checks++;
        if (lk_data_out[15:0] !== 16'h369C || lk_data_out[31:16] !== 16'h7F6C) begin
            n_fail++;
            $display("FAIL start_in_ready_new_table actual d0=%h d1=%h required d0=369c d1=7f6c",
                     lk_data_out[15:0], lk_data_out[31:16]);
        end
    endtask

    task automatic test_reset_mid_gen();
        do_start(16'h9000, 16'hFFF1);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_gen actual busy=%b ready=%b required 0 0", busy, ready);
        end
        step();
        rst_n = 1'b1;
        step();
        lookup(0, 1'b1, 0, 1'b1);
        n_checks++;
        if (lk_err !== 2'b11 || busy !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_gen_after actual err=%b busy=%b ready=%b required err=11 0 0",
                     lk_err, busy, ready);
        end
    endtask

    initial begin
        test_reset();
        test_nowrap();
        test_wrap();
        test_cfg_err();
        test_restart();
        test_start_in_ready();
        test_reset_mid_gen();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xpb_table_gen.md
Name: xpb_table_gen

Overview:
- Run-time generated replacement for the fixed xpb constant lookups used in modular-square reduction.
- After a start pulse, computes table entry k = (k * base_in) mod mod_in for k = 0 .. 2^IDX_W-1, one entry per clock, and stores the entries in registers.
- Serves NUM_LANES independent registered lookups per cycle to the reduction tree, so the modulus can change without regenerating RTL.

Parameters:
- DATA_W, 1024, width of modulus, base and table entries.
- IDX_W, 5, lookup index width; table depth is 2^IDX_W.
- NUM_LANES, 2, number of parallel lookup ports.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse: capture base_in/mod_in and (re)generate table.
- base_in  in  DATA_W  per-step increment (x*p*b constant); must be < mod_in.
- mod_in  in  DATA_W  modulus; must be nonzero.
- busy  out  1  generation in progress.
- ready  out  1  table valid; lookups are served.
- cfg_err  out  1  sticky; last start had base_in >= mod_in or mod_in == 0.
- lk_valid_in  in  NUM_LANES  per-lane lookup request.
- lk_idx_in  in  NUM_LANES*IDX_W  per-lane index, lane i at bits [i*IDX_W +: IDX_W].
- lk_valid_out  out  NUM_LANES  per-lane response valid.
- lk_data_out  out  NUM_LANES*DATA_W  per-lane entry, packed like lk_idx_in.
- lk_err  out  NUM_LANES  per-lane pulse: request arrived while not ready.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; busy, ready, cfg_err, lk_valid_out, lk_err = 0; lk_data_out = 0.
  - Table contents are don't-care, but ready = 0 blocks their use.
- FSM states: IDLE, GEN, READY.
  - IDLE/READY + start, with valid config: latch base/mod, write entry[0] = 0, acc = 0, k = 1, cfg_err cleared -> GEN.
  - Any state + start, with invalid config: cfg_err = 1, ready = 0 -> IDLE.
  - GEN: each cycle compute sum = acc + base at DATA_W+1 bits; if sum >= mod, use sum - mod, else sum. Write the result to entry[k], update acc, k++. When k = 2^IDX_W-1 is written -> READY.
  - GEN + start: abort and restart from k = 1 with the newly latched inputs.
  - READY holds until the next start or reset.
- Timing:
  - start sampled at edge 0.
  - entry[k] written at edge k.
  - busy is high from the cycle after edge 0 through edge 2^IDX_W-1.
  - ready is high from the cycle after edge 2^IDX_W-1 (31 cycles of busy for IDX_W = 5).
  - busy and ready are never both 1.
- Lookup:
  - Latency 1: lk_valid_in[i] at edge n gives lk_valid_out[i] = 1 and lk_data_out lane i = entry[idx] after edge n, when ready was 1 at edge n.
  - If ready was 0: lk_valid_out[i] = 0, lk_data_out lane i = 0, lk_err[i] = 1 for one cycle.
  - Idle lanes drive lk_valid_out = 0 and hold their last data.
  - Lanes are fully independent; the same index on several lanes is legal.
  - A start in READY drops ready at the next edge, so lookups in the same cycle as start are still served from the old table.
- Arithmetic:
  - No intermediate value exceeds DATA_W+1 bits.
  - entry[k] < mod for all k, given a valid config.
- Reset mid-GEN returns to IDLE with ready = 0.

Optional Feature:
- Macro: XPB_TABLE_LOOKUP_PIPE_EN.
- Defined: adds a second output register stage on lk_valid_out/lk_data_out/lk_err. Lookup latency is 2. The ready check still uses ready at request time.
- Undefined: latency 1 as above.
- GEN timing is identical either way.

Test Plan:
- Reset then lookup: DATA_W = 16, IDX_W = 3; lane 0 request idx 3 before any start -> lk_err[0] pulses 1, lk_valid_out[0] = 0, data 0.
- No-wrap generation: base = 0x1234, mod = 0xFFF1, start -> busy for 7 cycles, then ready. Lookups of idx 0..7 -> 0x0000, 0x1234, 0x2468, 0x369C, 0x48D0, 0x5B04, 0x6D38, 0x7F6C.
- Wrap generation: base = 0x9000, mod = 0xFFF1 -> entries 0x0000, 0x9000, 0x200F, 0xB00F, 0x401E, 0xD01E, 0x602D, 0xF02D. Two lanes reading idx 2 and idx 7 in the same cycle return 0x200F and 0xF02D one cycle later.
- Config error: base = 0xFFF1, mod = 0xFFF1, start -> cfg_err = 1, ready = 0, busy never asserts. Next valid start clears cfg_err.
- Restart mid-GEN: start with base = 0x1234, then start again at edge 3 with base = 0x9000 -> final table equals the wrap case, and ready rises 7 cycles after the second start.
- Async reset asserted mid-GEN -> busy/ready drop immediately. With XPB_TABLE_LOOKUP_PIPE_EN defined, the no-wrap scenario returns data two cycles after the request.
